// File: rtl/bus_slave_regs.sv
// Bus slave with seven read/write word registers and a read-only
// transaction counter, answering each strobe after a programmable wait.
module bus_slave_regs #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_,
    input  logic        as_,
    input  logic        rw,
    input  logic [29:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rdy_
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic        rw_q, rw_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] regs_q [7];
    logic [31:0] regs_d [7];
    logic [15:0] txn_cnt_q, txn_cnt_d;

    logic req;
    logic ack;
    logic unused_addr;

    assign req         = !cs_ && !as_;
    assign ack         = (state_q == ST_ACK);
    assign unused_addr = ^addr[29:3];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    idx_d   = addr[2:0];
                    rw_d    = rw;
                    wdata_d = wr_data;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // a dropped strobe abandons the transaction outright
                if (!req) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        txn_cnt_d = txn_cnt_q;
        for (int i = 0; i < 7; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (ack) begin
            txn_cnt_d = txn_cnt_q + 16'd1;
            for (int i = 0; i < 7; i++) begin
                if (!rw_q && idx_q == 3'(i)) begin
                    regs_d[i] = wdata_q;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (ack && rw_q) begin
            // the counter reads its value before this ACK's increment
            if (idx_q == 3'd7) begin
                rd_data = {16'h0000, txn_cnt_q};
            end else begin
                for (int i = 0; i < 7; i++) begin
                    if (idx_q == 3'(i)) begin
                        rd_data = regs_q[i];
                    end
                end
            end
        end
    end

    assign rdy_ = !ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            txn_cnt_q <= '0;
            for (int i = 0; i < 7; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rw_q      <= rw_d;
            wdata_q   <= wdata_d;
            txn_cnt_q <= txn_cnt_d;
            for (int i = 0; i < 7; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_bus_slave_regs.sv
// Randomised bench for bus_slave_regs against an array/counter model,
// with a second zero-wait instance for the minimum-latency case.
module tb_bus_slave_regs;

    localparam int WC = 2;

    logic        clk;
    logic        reset;
    logic        cs_, as_, rw;
    logic [29:0] addr;
    logic [31:0] wr_data, rd_data;
    logic        rdy_;

    logic        cs0_, as0_, rw0;
    logic [29:0] addr0;
    logic [31:0] wd0, rd0;
    logic        rdy0_;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_regs [8];
    int          m_cnt;

    bus_slave_regs #(.WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_)
    );

    bus_slave_regs #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .cs_(cs0_), .as_(as0_), .rw(rw0),
        .addr(addr0), .wr_data(wd0), .rd_data(rd0), .rdy_(rdy0_)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_cnt = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] idx);
        if (idx == 3'd7) return {16'h0000, 16'(m_cnt)};
        return m_regs[idx];
    endfunction

    task automatic m_complete(input logic r, input logic [2:0] idx,
                              input logic [31:0] d);
        if (!r && idx != 3'd7) m_regs[idx] = d;
        m_cnt = (m_cnt + 1) % 65536;
    endtask

    task automatic txn(input logic r, input logic [2:0] idx,
                       input logic [31:0] d,
                       output logic [31:0] rdv, output int lat);
        logic [29:0] a;
        a = 30'($urandom);
        a[2:0] = idx;
        @(negedge clk);
        cs_ = 1'b0; as_ = 1'b0; rw = r; addr = a; wr_data = d;
        lat = -1;
        rdv = '0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (rdy_ === 1'b0) begin
                lat = n;
                rdv = rd_data;
                break;
            end
        end
        cs_ = 1'b1; as_ = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; cs_ = 1'b1; as_ = 1'b1; cs0_ = 1'b1; as0_ = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        int lat;
        reset = 1'b1;
        cs_ = 1'b1; as_ = 1'b1; rw = 1'b0; addr = '0; wr_data = '0;
        cs0_ = 1'b1; as0_ = 1'b1; rw0 = 1'b0; addr0 = '0; wd0 = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rdy_ !== 1'b1 || rd_data !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_out: rdy_=%b rd=%h want 1/0", rdy_, rd_data);
        end
        n_cmp++;
        if (rdy0_ !== 1'b1 || rd0 !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_out0: rdy_=%b rd=%h want 1/0", rdy0_, rd0);
        end
        reset = 1'b0;
        m_reset();
        for (int i = 0; i < 8; i++) begin
            txn(1'b1, 3'(i), 32'h0, v, lat);
            n_cmp++;
            if (v !== m_read(3'(i)) || lat !== WC + 1) begin
                n_bad++;
                $display("FAIL reset_read[%0d]: got %h lat %0d want %h lat %0d",
                         i, v, lat, m_read(3'(i)), WC + 1);
            end
            m_complete(1'b1, 3'(i), 32'h0);
        end
    endtask

    task automatic test_spec_write();
        logic [31:0] v;
        int lat;
        txn(1'b0, 3'd3, 32'hDEADBEEF, v, lat);
        n_cmp++;
        if (lat !== 3 || v !== 32'h0) begin
            n_bad++;
            $display("FAIL spec_write: lat %0d rd %h want 3/0", lat, v);
        end
        m_complete(1'b0, 3'd3, 32'hDEADBEEF);
        @(negedge clk);
        n_cmp++;
        if (rdy_ !== 1'b1 || rd_data !== 32'h0) begin
            n_bad++;
            $display("FAIL ack_width: rdy_=%b rd=%h want 1/0", rdy_, rd_data);
        end
        txn(1'b1, 3'd3, 32'h0, v, lat);
        n_cmp++;
        if (v !== 32'hDEADBEEF || lat !== 3) begin
            n_bad++;
            $display("FAIL spec_read: got %h lat %0d want deadbeef/3", v, lat);
        end
        m_complete(1'b1, 3'd3, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] v, d, e;
        logic [2:0]  idx;
        logic        r;
        int lat;
        for (int k = 0; k < 40; k++) begin
            r   = 1'($urandom);
            idx = 3'($urandom);
            d   = $urandom;
            e   = r ? m_read(idx) : 32'h0;
            txn(r, idx, d, v, lat);
            n_cmp++;
            if (v !== e) begin
                n_bad++;
                $display("FAIL rand_data[%0d] rw=%b idx=%0d: got %h want %h",
                         k, r, idx, v, e);
            end
            n_cmp++;
            if (lat !== WC + 1) begin
                n_bad++;
                $display("FAIL rand_lat[%0d]: got %0d want %0d", k, lat, WC + 1);
            end
            m_complete(r, idx, d);
        end
    endtask

    task automatic test_back_to_back();
        int p [2];
        logic [31:0] d [2];
        int np;
        logic [31:0] e;
        np = 0;
        @(negedge clk);
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = 30'h7;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (rdy_ === 1'b0) begin
                p[np] = n;
                d[np] = rd_data;
                np++;
                if (np == 2) break;
            end
        end
        cs_ = 1'b1; as_ = 1'b1;
        n_cmp++;
        if (np !== 2) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d pulses want 2", np);
        end else begin
            n_cmp++;
            if (p[1] - p[0] - 1 !== WC + 1) begin
                n_bad++;
                $display("FAIL b2b_gap: got %0d high cycles want %0d",
                         p[1] - p[0] - 1, WC + 1);
            end
            for (int i = 0; i < 2; i++) begin
                e = m_read(3'd7);
                n_cmp++;
                if (d[i] !== e) begin
                    n_bad++;
                    $display("FAIL b2b_r7[%0d]: got %h want %h", i, d[i], e);
                end
                m_complete(1'b1, 3'd7, 32'h0);
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] v;
        int lat;
        logic saw;
        do_reset();
        @(negedge clk);
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = 30'h1;
        wr_data = 32'h12345678;
        @(negedge clk);
        as_ = 1'b1;
        saw = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rdy_ !== 1'b1) saw = 1'b1;
        end
        cs_ = 1'b1;
        n_cmp++;
        if (saw !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_pulse: rdy_ went low want none");
        end
        txn(1'b1, 3'd7, 32'h0, v, lat);
        n_cmp++;
        if (v !== 32'h0) begin
            n_bad++;
            $display("FAIL abort_r7: got %h want 0", v);
        end
        m_complete(1'b1, 3'd7, 32'h0);
        txn(1'b1, 3'd1, 32'h0, v, lat);
        n_cmp++;
        if (v !== 32'h0) begin
            n_bad++;
            $display("FAIL abort_r1: got %h want 0", v);
        end
        m_complete(1'b1, 3'd1, 32'h0);
    endtask

    task automatic test_counter();
        logic [31:0] v, e;
        int lat;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            txn(1'b0, 3'(k), $urandom, v, lat);
            m_complete(1'b0, 3'(k), 32'h0);
        end
        txn(1'b1, 3'd7, 32'h0, v, lat);
        n_cmp++;
        if (v !== 32'h3) begin
            n_bad++;
            $display("FAIL cnt_three: got %h want 3", v);
        end
        m_complete(1'b1, 3'd7, 32'h0);
        txn(1'b0, 3'd7, 32'hFFFFFFFF, v, lat);
        n_cmp++;
        if (lat !== WC + 1 || v !== 32'h0) begin
            n_bad++;
            $display("FAIL r7_write_ack: lat %0d rd %h want %0d/0",
                     lat, v, WC + 1);
        end
        m_complete(1'b0, 3'd7, 32'hFFFFFFFF);
        e = m_read(3'd7);
        txn(1'b1, 3'd7, 32'h0, v, lat);
        n_cmp++;
        if (v !== e) begin
            n_bad++;
            $display("FAIL r7_after_write: got %h want %h", v, e);
        end
        m_complete(1'b1, 3'd7, 32'h0);
        @(negedge clk);
        dut.txn_cnt_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        txn(1'b1, 3'd7, 32'h0, v, lat);
        n_cmp++;
        if (v !== 32'h0000FFFF) begin
            n_bad++;
            $display("FAIL r7_max: got %h want 0000ffff", v);
        end
        m_complete(1'b1, 3'd7, 32'h0);
        txn(1'b1, 3'd7, 32'h0, v, lat);
        n_cmp++;
        if (v !== 32'h0) begin
            n_bad++;
            $display("FAIL r7_wrap: got %h want 0", v);
        end
        m_complete(1'b1, 3'd7, 32'h0);
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] v;
        int lat;
        logic saw;
        @(negedge clk);
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = 30'h2;
        wr_data = 32'hA5A5A5A5;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rdy_ !== 1'b1 || rd_data !== 32'h0) begin
            n_bad++;
            $display("FAIL midwait_out: rdy_=%b rd=%h want 1/0", rdy_, rd_data);
        end
        reset = 1'b0; cs_ = 1'b1; as_ = 1'b1;
        m_reset();
        saw = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rdy_ !== 1'b1) saw = 1'b1;
        end
        n_cmp++;
        if (saw !== 1'b0) begin
            n_bad++;
            $display("FAIL midwait_pulse: rdy_ went low want none");
        end
        txn(1'b1, 3'd2, 32'h0, v, lat);
        n_cmp++;
        if (v !== 32'h0 || lat !== WC + 1) begin
            n_bad++;
            $display("FAIL midwait_r2: got %h lat %0d want 0/%0d", v, lat, WC + 1);
        end
        m_complete(1'b1, 3'd2, 32'h0);
    endtask

    task automatic test_zero_wait();
        logic [31:0] v;
        logic [31:0] d;
        int lat;
        do_reset();
        for (int s = 0; s < 3; s++) begin
            d = 32'hCAFEF00D;
            @(negedge clk);
            cs0_ = 1'b0; as0_ = 1'b0; rw0 = (s != 1); addr0 = 30'h5;
            wd0 = d;
            lat = -1;
            v = '0;
            for (int n = 1; n <= 10; n++) begin
                @(negedge clk);
                if (rdy0_ === 1'b0) begin
                    lat = n;
                    v = rd0;
                    break;
                end
            end
            cs0_ = 1'b1; as0_ = 1'b1;
            n_cmp++;
            if (lat !== 1) begin
                n_bad++;
                $display("FAIL zw_lat[%0d]: got %0d want 1", s, lat);
            end
            n_cmp++;
            if (v !== ((s == 2) ? d : 32'h0)) begin
                n_bad++;
                $display("FAIL zw_data[%0d]: got %h want %h",
                         s, v, (s == 2) ? d : 32'h0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_spec_write();
        test_random();
        test_back_to_back();
        test_abort();
        test_counter();
        test_reset_mid_wait();
        test_zero_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
